uart_tx_sched: RTL and testbench

Packet-level scheduler that shares the single byte-serial UART transmitter among `N_REQ` biosignal stream sources. It arbitrates round-robin between requesters at packet boundaries and prefixes each packet with a one-byte channel header. It drives the transmitter's `data_i`/`valid_i`, paces bytes off its `busy_o`, and sits between the per-channel packetizers and the UART pin driver.

---
 rtl/uart_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_tx_sched.sv | 101 ++++++++++
 tb/tb_uart_tx_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART packet scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_FETCH   = 3'd4
  } sched_state_t;

  localparam logic [7:0] HDR_NIBBLE_MASK = 8'h0F;

  // Channel header: base in the high nibble, requester index in the low nibble.
  function automatic logic [7:0] make_hdr(input logic [7:0] base, input logic [3:0] idx);
    return (base & ~HDR_NIBBLE_MASK) | {4'h0, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first request at or after ptr+1 wins.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int unsigned GW = $clog2(N);

  int unsigned idx;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && req[GW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler sharing one byte-serial UART transmitter
// between N_REQ stream sources, prefixing each packet with a channel header.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter logic [7:0]  HDR_BASE = 8'hA0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0][7:0]       req_data_i,
  input  logic [N_REQ-1:0]            req_last_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [7:0]                  uart_data_o,
  output logic                        uart_valid_o,
  input  logic                        uart_busy_i,
  output logic [$clog2(N_REQ)-1:0]    grant_o,
  output logic                        active_o
);

  localparam int unsigned GW = $clog2(N_REQ);

  sched_state_t  state;
  logic [7:0]    byte_q;
  logic          last_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] arb_idx;
  logic          arb_any;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid_i),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign uart_data_o = byte_q;
  assign grant_o     = grant_q;

  // Packet FSM; strobe, ready and active are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      byte_q       <= 8'h00;
      last_q       <= 1'b0;
      grant_q      <= '0;
      rr_ptr       <= GW'(N_REQ - 1);
      uart_valid_o <= 1'b0;
      req_ready_o  <= '0;
      active_o     <= 1'b0;
    end else begin
      uart_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en_i && arb_any) begin
            grant_q      <= arb_idx;
            rr_ptr       <= arb_idx;
            byte_q       <= make_hdr(HDR_BASE, 4'(arb_idx));
            last_q       <= 1'b0;
            uart_valid_o <= 1'b1;
            active_o     <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT_HI;
        ST_WAIT_HI: begin
          if (uart_busy_i) state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!uart_busy_i) begin
            if (last_q) begin
              active_o <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              req_ready_o <= N_REQ'(1) << grant_q;
              state       <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (req_valid_i[grant_q]) begin
            byte_q       <= req_data_i[grant_q];
            last_q       <= req_last_i[grant_q];
            uart_valid_o <= 1'b1;
            req_ready_o  <= '0;
            state        <= ST_ISSUE;
          end
        end
        default: begin
          req_ready_o <= '0;
          active_o    <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: transmitter model, queue-driven requesters and a
// packet-order reference model.
module tb_uart_tx_sched;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en_i = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0][7:0] req_data = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready_o;
  logic [7:0]       uart_data_o;
  logic             uart_valid_o;
  logic             uart_busy = 1'b0;
  logic [1:0]       grant_o;
  logic             active_o;

  int checks = 0;
  int errors = 0;

  uart_tx_sched #(.N_REQ(N), .HDR_BASE(8'hA0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready_o),
    .uart_data_o  (uart_data_o),
    .uart_valid_o (uart_valid_o),
    .uart_busy_i  (uart_busy),
    .grant_o      (grant_o),
    .active_o     (active_o)
  );

  always #5 clk = ~clk;

  // Transmitter model: loads on strobe when idle, busy for one 10-bit frame.
  logic [7:0] txq[$];
  int         tx_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_busy <= 1'b0;
      tx_cnt    <= 0;
    end else if (uart_valid_o && !uart_busy) begin
      txq.push_back(uart_data_o);
      uart_busy <= 1'b1;
      tx_cnt    <= FRAME;
    end else if (uart_busy) begin
      if (tx_cnt <= 1) uart_busy <= 1'b0;
      tx_cnt <= tx_cnt - 1;
    end
  end

  // Requesters: per-channel byte queues {last, data}; gaps only mid-packet.
  logic [8:0] rq [N][$];
  bit         pend [N];
  bit         mid [N];
  bit         hold [N];
  bit         gap_mode = 1'b0;
  int         rdy_rise [N];
  logic [N-1:0] rdy_prev = '0;

  always @(negedge clk) begin
    logic [8:0] b;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        b = rq[i].pop_front();
        mid[i] = !b[8];
        pend[i] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 &&
          !(mid[i] && (hold[i] || (gap_mode && $urandom_range(0, 2) == 0)))) begin
        req_valid[i] = 1'b1;
        req_data[i]  = rq[i][0][7:0];
        req_last[i]  = rq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'($urandom);
        req_last[i]  = 1'($urandom);
      end
      pend[i] = req_valid[i] && req_ready_o[i];
      if (req_ready_o[i] && !rdy_prev[i]) rdy_rise[i]++;
    end
    rdy_prev = req_ready_o;
  end

  // Transmitter handshake and ready exclusivity, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (uart_valid_o && uart_busy) begin
        errors++;
        $display("FAIL hs_valid_while_busy t=%0t valid=%b busy=%b", $time, uart_valid_o, uart_busy);
      end
      assert ($onehot0(req_ready_o)) else begin
        errors++;
        $display("FAIL ready_onehot t=%0t ready=%b", $time, req_ready_o);
      end
    end
  end

  // Reference model: packets already queued, served in rotate-priority order.
  logic [8:0] mq [N][$];
  logic [7:0] expq[$];
  int         m_ptr = N - 1;

  task automatic model_run();
    int w;
    logic [8:0] b;
    forever begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      if (w < 0) break;
      expq.push_back(8'hA0 | 8'(w));
      do begin
        b = mq[w].pop_front();
        expq.push_back(b[7:0]);
      end while (!b[8] && mq[w].size() > 0);
      m_ptr = w;
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last, input bit to_model);
    rq[r].push_back({last, d});
    if (to_model) mq[r].push_back({last, d});
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    bit done;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      done = !active_o && !uart_busy;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0 || pend[i]) done = 1'b0;
      ok = done;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (req_ready_o !== 4'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0000", req_ready_o); end
    if (uart_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", uart_valid_o); end
    if (uart_data_o !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", uart_data_o); end
    if (grant_o !== 2'd0) begin errors++; $display("FAIL rst_grant got=%0d exp=0", grant_o); end
    if (active_o !== 1'b0) begin errors++; $display("FAIL rst_active got=%b exp=0", active_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int busy_fall = -1, act_fall = -1;
    logic busy_p, act_p;
    rdy_rise[0] = 0;
    push_byte(0, 8'h11, 1'b0, 1'b1);
    push_byte(0, 8'h22, 1'b1, 1'b1);
    model_run();
    en_i = 1'b1;
    busy_p = 1'b0; act_p = 1'b0;
    for (int c = 0; c < 1000 && act_fall < 0; c++) begin
      @(negedge clk);
      if (busy_p && !uart_busy) busy_fall = c;
      if (act_p && !active_o) act_fall = c;
      busy_p = uart_busy; act_p = active_o;
    end
    wait_drain(200, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL single_timeout got=0 exp=1"); end
    if (rdy_rise[0] !== 2) begin errors++; $display("FAIL single_ready_pulses got=%0d exp=2", rdy_rise[0]); end
    if (act_fall - busy_fall !== 1) begin errors++; $display("FAIL single_active_fall got=%0d exp=1", act_fall - busy_fall); end
    if (txq.size() !== expq.size()) begin errors++; $display("FAIL single_len got=%0d exp=%0d", txq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== expq[i]) begin errors++; $display("FAIL single_byte%0d got=%h exp=%h", i, txq[i], expq[i]); end
    end
    txq.delete(); expq.delete();
  endtask

  task automatic test_stall();
    bit ok, bad_v, bad_g, bad_r, bad_t;
    rdy_rise[1] = 0;
    hold[1] = 1'b1;
    push_byte(1, 8'h5A, 1'b0, 1'b1);
    push_byte(1, 8'h5B, 1'b1, 1'b1);
    push_byte(3, 8'h77, 1'b1, 1'b1);
    model_run();
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      ok = (rdy_rise[1] >= 2);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_reach_fetch got=0 exp=1"); end
    bad_v = 0; bad_g = 0; bad_r = 0; bad_t = 0;
    repeat (50) begin
      @(negedge clk);
      if (uart_valid_o !== 1'b0) bad_v = 1;
      if (grant_o !== 2'd1 || active_o !== 1'b1) bad_g = 1;
      if (req_ready_o !== 4'b0010) bad_r = 1;
      if (txq.size() !== 2) bad_t = 1;
    end
    checks += 4;
    if (bad_v) begin errors++; $display("FAIL stall_valid got=1 exp=0"); end
    if (bad_g) begin errors++; $display("FAIL stall_grant got=%0d exp=1", grant_o); end
    if (bad_r) begin errors++; $display("FAIL stall_ready got=%b exp=0010", req_ready_o); end
    if (bad_t) begin errors++; $display("FAIL stall_txcount got=%0d exp=2", txq.size()); end
    hold[1] = 1'b0;
    wait_drain(1000, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL stall_timeout got=0 exp=1"); end
    if (txq.size() !== expq.size()) begin errors++; $display("FAIL stall_len got=%0d exp=%0d", txq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== expq[i]) begin errors++; $display("FAIL stall_byte%0d got=%h exp=%h", i, txq[i], expq[i]); end
    end
    txq.delete(); expq.delete();
  endtask

  task automatic test_contention();
    bit ok;
    for (int round = 0; round < 2; round++) begin
      en_i = 1'b0;
      for (int r = 0; r < N; r++)
        if (round == 0 || r == 0 || r == 2) push_byte(r, 8'hC0 | 8'(r), 1'b1, 1'b1);
      model_run();
      repeat (2) @(negedge clk);
      en_i = 1'b1;
      wait_drain(2000, ok);
      checks += 2;
      if (!ok) begin errors++; $display("FAIL contention%0d_timeout got=0 exp=1", round); end
      if (txq.size() !== expq.size()) begin errors++; $display("FAIL contention%0d_len got=%0d exp=%0d", round, txq.size(), expq.size()); end
      for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
        checks++;
        if (txq[i] !== expq[i]) begin errors++; $display("FAIL contention%0d_byte%0d got=%h exp=%h", round, i, txq[i], expq[i]); end
      end
      txq.delete(); expq.delete();
    end
  endtask

  task automatic test_enable();
    bit ok, bad;
    logic [7:0] d3 [2];
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(2, 8'($urandom), i == 2, 1'b1);
    model_run();
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin @(negedge clk); ok = (txq.size() >= 1); end
    en_i = 1'b0;
    for (int i = 0; i < 2; i++) begin d3[i] = 8'($urandom); push_byte(3, d3[i], i == 1, 1'b0); end
    for (int c = 0; c < 1000 && !(txq.size() >= 4 && !active_o); c++) @(negedge clk);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (active_o !== 1'b0 || txq.size() !== 4 || uart_valid_o !== 1'b0) bad = 1;
    end
    checks += 3;
    if (bad) begin errors++; $display("FAIL en_hold_idle got=%0d bytes exp=4", txq.size()); end
    if (rq[3].size() !== 2) begin errors++; $display("FAIL en_pending got=%0d exp=2", rq[3].size()); end
    en_i = 1'b1;
    for (int i = 0; i < 2; i++) mq[3].push_back({i == 1, d3[i]});
    model_run();
    wait_drain(1000, ok);
    if (!ok) begin errors++; $display("FAIL en_timeout got=0 exp=1"); end
    checks++;
    if (txq.size() !== expq.size()) begin errors++; $display("FAIL en_len got=%0d exp=%0d", txq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== expq[i]) begin errors++; $display("FAIL en_byte%0d got=%h exp=%h", i, txq[i], expq[i]); end
    end
    txq.delete(); expq.delete();
  endtask

  task automatic test_random();
    bit ok;
    int npk, len;
    gap_mode = 1'b1;
    for (int it = 0; it < 2; it++) begin
      en_i = 1'b0;
      for (int r = 0; r < N; r++) begin
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1, 1'b1);
        end
      end
      model_run();
      repeat (2) @(negedge clk);
      en_i = 1'b1;
      wait_drain(6000, ok);
      checks += 2;
      if (!ok) begin errors++; $display("FAIL rand%0d_timeout got=0 exp=1", it); end
      if (txq.size() !== expq.size()) begin errors++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, txq.size(), expq.size()); end
      for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
        checks++;
        if (txq[i] !== expq[i]) begin errors++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", it, i, txq[i], expq[i]); end
      end
      txq.delete(); expq.delete();
    end
    gap_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    en_i = 1'b1;
    rdy_rise[2] = 0;
    hold[2] = 1'b1;
    push_byte(2, 8'h31, 1'b0, 1'b0);
    push_byte(2, 8'h32, 1'b1, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin @(negedge clk); ok = (rdy_rise[2] >= 2); end
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_reach_fetch got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (req_ready_o !== 4'b0) begin errors++; $display("FAIL rmid_ready got=%b exp=0000", req_ready_o); end
    if (uart_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", uart_valid_o); end
    if (uart_data_o !== 8'h00) begin errors++; $display("FAIL rmid_data got=%h exp=00", uart_data_o); end
    if (grant_o !== 2'd0) begin errors++; $display("FAIL rmid_grant got=%0d exp=0", grant_o); end
    if (active_o !== 1'b0) begin errors++; $display("FAIL rmid_active got=%b exp=0", active_o); end
    for (int i = 0; i < N; i++) begin
      rq[i].delete(); mq[i].delete();
      mid[i] = 1'b0; pend[i] = 1'b0; hold[i] = 1'b0;
    end
    txq.delete(); expq.delete();
    m_ptr = N - 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en_i = 1'b0;
    push_byte(2, 8'h44, 1'b1, 1'b1);
    push_byte(0, 8'h55, 1'b1, 1'b1);
    model_run();
    repeat (2) @(negedge clk);
    en_i = 1'b1;
    wait_drain(1000, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL rmid_timeout got=0 exp=1"); end
    if (txq.size() !== expq.size()) begin errors++; $display("FAIL rmid_len got=%0d exp=%0d", txq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== expq[i]) begin errors++; $display("FAIL rmid_byte%0d got=%h exp=%h", i, txq[i], expq[i]); end
    end
    txq.delete(); expq.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; mid[i] = 1'b0; hold[i] = 1'b0; rdy_rise[i] = 0;
    end
    test_reset();
    test_single();
    test_stall();
    test_contention();
    test_enable();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
